// File: rtl/simplez_loader.sv
// simplez_loader: serial program loader, the write side of the SIMPLEZ program RAM.
// Accepts a checksummed frame of 12-bit words, writes them from address 0 and acks 'K' or 'E'.
module simplez_loader #(
  parameter int          AW        = 9,
  parameter int          DW        = 12,
  parameter int          MAX_WORDS = 504,
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter logic [23:0] TIMEOUT   = 24'd1200000,
  parameter logic        BOOT_RUN  = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_rcv,
  input  logic [7:0]    rx_data,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          ram_cs,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          cpu_rstn,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [7:0]  ACK_OK  = 8'h4B;
  localparam logic [7:0]  ACK_ERR = 8'h45;
  localparam logic [15:0] MAX_N   = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, W_HI, W_LO, WRITE, CHK, ACK
  } state_t;

  state_t        state_r;
  logic [AW-1:0] ptr_r;
  logic [7:0]    sum_r;
  logic [23:0]   timer_r;
  logic [15:0]   cnt_r;
  logic [DW-9:0] wh_r;
  logic [7:0]    ack_r;

  logic [15:0]   n_s;
  logic          cnt_bad_s;
  logic          timeout_s;
  logic          last_s;
  logic          sum_ok_s;
  logic          counting_s;

  function automatic logic [7:0] csum_add(input logic [7:0] s, input logic [7:0] b);
    return s + b;
  endfunction

  // Frame decode helpers; n_s is the word count as it completes with the CNT_L byte.
  always_comb begin
    n_s        = {cnt_r[15:8], rx_data};
    cnt_bad_s  = (n_s == 16'd0) || (n_s > MAX_N);
    timeout_s  = (timer_r == (TIMEOUT - 24'd1));
    last_s     = ({{(16-AW){1'b0}}, ptr_r} == (cnt_r - 16'd1));
    sum_ok_s   = (rx_data == sum_r);
    counting_s = (state_r != IDLE) && (state_r != ACK);
  end

  // Frame sequencer: consumes bytes, issues one-cycle RAM writes and emits the ack byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      sum_r    <= 8'h00;
      timer_r  <= 24'd0;
      cnt_r    <= 16'h0000;
      wh_r     <= '0;
      ack_r    <= 8'h00;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      ram_cs   <= 1'b0;
      ram_rw   <= 1'b1;
      ram_addr <= '0;
      ram_din  <= '0;
      cpu_rstn <= BOOT_RUN;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      ram_cs   <= 1'b0;
      ram_rw   <= 1'b1;
      if (rx_rcv) begin
        timer_r <= 24'd0;
      end else if (counting_s) begin
        timer_r <= timer_r + 24'd1;
      end
      case (state_r)
        IDLE: begin
          if (rx_rcv && (rx_data == SYNC)) begin
            done     <= 1'b0;
            error    <= 1'b0;
            sum_r    <= 8'h00;
            ptr_r    <= '0;
            cpu_rstn <= 1'b0;
            busy     <= 1'b1;
            state_r  <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (rx_rcv) begin
            cnt_r   <= {rx_data, 8'h00};
            sum_r   <= csum_add(sum_r, rx_data);
            state_r <= CNT_LO;
          end else if (timeout_s) begin
            error   <= 1'b1;
            ack_r   <= ACK_ERR;
            state_r <= ACK;
          end
        end
        CNT_LO: begin
          if (rx_rcv) begin
            cnt_r[7:0] <= rx_data;
            sum_r      <= csum_add(sum_r, rx_data);
            if (cnt_bad_s) begin
              error   <= 1'b1;
              ack_r   <= ACK_ERR;
              state_r <= ACK;
            end else begin
              state_r <= W_HI;
            end
          end else if (timeout_s) begin
            error   <= 1'b1;
            ack_r   <= ACK_ERR;
            state_r <= ACK;
          end
        end
        W_HI: begin
          if (rx_rcv) begin
            wh_r    <= rx_data[DW-9:0];
            sum_r   <= csum_add(sum_r, rx_data);
            state_r <= W_LO;
          end else if (timeout_s) begin
            error   <= 1'b1;
            ack_r   <= ACK_ERR;
            state_r <= ACK;
          end
        end
        W_LO: begin
          if (rx_rcv) begin
            // Strobe is registered here so it is high exactly during the WRITE cycle.
            ram_cs   <= 1'b1;
            ram_rw   <= 1'b0;
            ram_addr <= ptr_r;
            ram_din  <= {wh_r, rx_data};
            sum_r    <= csum_add(sum_r, rx_data);
            state_r  <= WRITE;
          end else if (timeout_s) begin
            error   <= 1'b1;
            ack_r   <= ACK_ERR;
            state_r <= ACK;
          end
        end
        WRITE: begin
          ptr_r   <= ptr_r + AW'(1);
          state_r <= last_s ? CHK : W_HI;
        end
        CHK: begin
          if (rx_rcv) begin
            if (sum_ok_s) begin
              done     <= 1'b1;
              cpu_rstn <= 1'b1;
              ack_r    <= ACK_OK;
            end else begin
              error <= 1'b1;
              ack_r <= ACK_ERR;
            end
            state_r <= ACK;
          end else if (timeout_s) begin
            error   <= 1'b1;
            ack_r   <= ACK_ERR;
            state_r <= ACK;
          end
        end
        ACK: begin
          timer_r <= 24'd0;
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= ack_r;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_loader.sv
// Self-checking bench for simplez_loader: table vectors, hand-built corner sequences and
// random frames checked against a frame-level reference model.
module tb_simplez_loader;

  localparam int AW = 9;
  localparam int DW = 12;
  localparam logic [7:0] K_BYTE = 8'h4B;
  localparam logic [7:0] E_BYTE = 8'h45;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_rcv;
  logic [7:0]    rx_data;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          ram_cs;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          cpu_rstn;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad = 0;

  logic [21:0] wlog[$];
  int          tx_cnt = 0;

  logic [7:0]  frame_q[$];
  logic [20:0] exp_q[$];
  logic [7:0]  exp_ack;

  typedef struct {
    int          len;
    logic [95:0] bytes;
    logic [7:0]  ack;
    int          nw;
    logic [11:0] w0;
    logic [11:0] w1;
  } vec_t;

  vec_t tbl [7];

  simplez_loader #(.TIMEOUT(24'd100)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_rcv   (rx_rcv),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .ram_cs   (ram_cs),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Record every RAM strobe and ack pulse seen by the outside world.
  always @(negedge clk) begin
    if (ram_cs === 1'b1) wlog.push_back({ram_rw, ram_addr, ram_din});
    if (tx_start === 1'b1) tx_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_rcv  = 1'b1;
    rx_data = b;
    tick();
    rx_rcv  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input int gmax);
    for (int i = 0; i < frame_q.size(); i++)
      send_byte(frame_q[i], (i == frame_q.size() - 1) ? 0 : $urandom_range(1, gmax));
  endtask

  task automatic wait_ack(output int lat, output logic [7:0] b);
    lat = 0;
    b = 8'h00;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (tx_start === 1'b1) begin
        lat = k;
        b = tx_data;
        break;
      end
    end
  endtask

  // Frame-level reference: count rule, word packing and mod-256 checksum.
  task automatic model_frame();
    int n;
    int s;
    exp_q.delete();
    n = {frame_q[1], frame_q[2]};
    if (n == 0 || n > 504) begin
      exp_ack = E_BYTE;
    end else begin
      s = 0;
      for (int i = 1; i < frame_q.size() - 1; i++) s = s + frame_q[i];
      for (int i = 0; i < n; i++)
        exp_q.push_back({9'(i), frame_q[3 + 2*i][3:0], frame_q[4 + 2*i]});
      exp_ack = (frame_q[frame_q.size() - 1] == 8'(s)) ? K_BYTE : E_BYTE;
    end
  endtask

  task automatic check_frame(input string nm, input int base);
    int lat;
    logic [7:0] b;
    int nw;
    wait_ack(lat, b);
    chk({nm, " ack_latency"}, lat, 1);
    chk({nm, " ack_byte"}, b, exp_ack);
    chk({nm, " done"}, done, exp_ack == K_BYTE);
    chk({nm, " error"}, error, exp_ack == E_BYTE);
    chk({nm, " cpu_rstn"}, cpu_rstn, exp_ack == K_BYTE);
    chk({nm, " busy"}, busy, 0);
    nw = wlog.size() - base;
    chk({nm, " write_count"}, nw, exp_q.size());
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      chk({nm, " write"}, wlog[base + i], {1'b0, exp_q[i]});
  endtask

  task automatic rand_frame(input int n, input bit good);
    int s;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[15:8]);
    frame_q.push_back(n[7:0]);
    if (n >= 1 && n <= 504) begin
      s = n[15:8] + n[7:0];
      for (int i = 0; i < 2*n; i++) begin
        frame_q.push_back(8'($urandom_range(0, 255)));
        s = s + frame_q[frame_q.size() - 1];
      end
      frame_q.push_back(good ? 8'(s) : 8'(s + $urandom_range(1, 255)));
    end
  endtask

  task automatic set_vec(input int idx, input int len, input logic [95:0] bytes,
                         input logic [7:0] ack, input int nw,
                         input logic [11:0] w0, input logic [11:0] w1);
    tbl[idx].len = len;
    tbl[idx].bytes = bytes;
    tbl[idx].ack = ack;
    tbl[idx].nw = nw;
    tbl[idx].w0 = w0;
    tbl[idx].w1 = w1;
  endtask

  task automatic load_vec(input int v);
    frame_q.delete();
    exp_q.delete();
    for (int i = 0; i < tbl[v].len; i++)
      frame_q.push_back(tbl[v].bytes[8*(tbl[v].len - 1 - i) +: 8]);
    if (tbl[v].nw > 0) exp_q.push_back({9'd0, tbl[v].w0});
    if (tbl[v].nw > 1) exp_q.push_back({9'd1, tbl[v].w1});
    exp_ack = tbl[v].ack;
  endtask

  initial begin
    int base;
    int t0;
    int seen;
    int n;
    logic err99;
    logic err100;

    set_vec(0, 8, 96'({8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0E, 8'h45, 8'h79}), K_BYTE, 2, 12'h123, 12'hE45);
    set_vec(1, 8, 96'({8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0E, 8'h45, 8'h78}), E_BYTE, 2, 12'h123, 12'hE45);
    set_vec(2, 3, 96'({8'hA5, 8'h00, 8'h00}), E_BYTE, 0, 12'h000, 12'h000);
    set_vec(3, 3, 96'({8'hA5, 8'h01, 8'hF9}), E_BYTE, 0, 12'h000, 12'h000);
    set_vec(4, 6, 96'({8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02}), E_BYTE, 1, 12'h000, 12'h000);
    set_vec(5, 6, 96'({8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h4B}), K_BYTE, 1, 12'h5A5, 12'h000);
    set_vec(6, 6, 96'({8'hA5, 8'h00, 8'h01, 8'hF3, 8'h21, 8'h15}), K_BYTE, 1, 12'h321, 12'h000);

    rstn = 1'b0;
    rx_rcv = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst tx_start", tx_start, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst ram_cs", ram_cs, 0);
    chk("rst ram_rw", ram_rw, 1);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_din", ram_din, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst cpu_rstn", cpu_rstn, 1);
    rstn = 1'b1;
    tick();

    // Noise before SYNC must be ignored.
    t0 = tx_cnt;
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h3C, 3);
    chk("noise busy", busy, 0);
    chk("noise no_ack", tx_cnt, t0);
    chk("noise cpu_rstn", cpu_rstn, 1);

    for (int v = 0; v < 7; v++) begin
      load_vec(v);
      base = wlog.size();
      send_frame(1);
      check_frame($sformatf("vec%0d", v), base);
    end

    // A byte arriving during the WRITE cycle is dropped.
    frame_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
    model_frame();
    base = wlog.size();
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 0);
    send_byte(8'h77, 1);
    send_byte(8'h47, 0);
    check_frame("drop_in_write", base);

    // Ack held off while tx_ready is low.
    load_vec(0);
    base = wlog.size();
    tx_ready = 1'b0;
    send_frame(2);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (tx_start === 1'b1) seen++;
    end
    chk("txready_low no_start", seen, 0);
    chk("txready_low busy", busy, 1);
    tx_ready = 1'b1;
    check_frame("txready_low", base);

    // Timeout after a lone WH byte.
    frame_q = '{8'hA5, 8'h00, 8'h01};
    exp_q.delete();
    exp_ack = E_BYTE;
    base = wlog.size();
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h12, 0);
    err99 = 1'b0;
    err100 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 99) err99 = error;
      if (k == 100) err100 = error;
    end
    chk("timeout error_at_99", err99, 0);
    chk("timeout error_at_100", err100, 1);
    check_frame("timeout", base);

    rand_frame(3, 1'b1);
    model_frame();
    base = wlog.size();
    send_frame(2);
    check_frame("after_timeout", base);

    // Reset pulse in the middle of a word.
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h01, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst ram_addr", ram_addr, 0);
    chk("midrst ram_din", ram_din, 0);
    chk("midrst tx_data", tx_data, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst error", error, 0);
    chk("midrst cpu_rstn", cpu_rstn, 1);
    base = wlog.size();
    t0 = tx_cnt;
    send_byte(8'h23, 1);
    send_byte(8'h0E, 1);
    send_byte(8'h45, 1);
    send_byte(8'h79, 1);
    repeat (20) tick();
    chk("midrst no_write", wlog.size(), base);
    chk("midrst no_ack", tx_cnt, t0);
    chk("midrst idle", busy, 0);

    // Largest legal load.
    rand_frame(504, 1'b1);
    model_frame();
    base = wlog.size();
    send_frame(1);
    check_frame("max_words", base);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0)
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(505, 65535);
      else
        n = $urandom_range(1, 8);
      rand_frame(n, $urandom_range(0, 3) != 0);
      model_frame();
      base = wlog.size();
      send_frame(3);
      check_frame($sformatf("rand%0d", r), base);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
